multi_debounce: RTL and testbench

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_chan.sv | 96 +++++++++
 rtl/multi_debounce.sv | 58 +++++
 tb/tb_multi_debounce.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared defaults, range limits and counter sizing for the debouncer.
// Revision : 1.0
// ============================================================================
package debounce_pkg;

    localparam int c_default_n      = 4;
    localparam int c_default_bounce = 50000;
    localparam int c_default_hold   = 0;
    localparam bit c_default_init   = 1'b0;

    localparam int c_n_min      = 1;
    localparam int c_n_max      = 32;
    localparam int c_bounce_min = 1;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : debounce_chan
// Brief    : One switch channel: 2-flop sync, stability counter, edge pulses, hold.
// Revision : 1.0
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int BOUNCE = c_default_bounce,
    parameter int HOLD   = c_default_hold,
    parameter bit INIT   = c_default_init
) (
    input  logic CLK,
    input  logic RST,
    input  logic sw,
    output logic outp,
    output logic invoutp,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int            c_cw     = cnt_width(BOUNCE);
    localparam logic [c_cw-1:0] c_reload = c_cw'(BOUNCE);
    localparam logic [c_cw-1:0] c_one    = c_cw'(1);

    logic            r_s1;
    logic            r_s2;
    logic            r_lsw;
    logic [c_cw-1:0] r_cnt;
    logic            r_outp;
    logic            r_rise;
    logic            r_fall;

    // The level is only accepted once the counter has drained with the
    // synchronized input unchanged; any change reloads the full interval.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1   <= INIT;
            r_s2   <= INIT;
            r_lsw  <= INIT;
            r_outp <= INIT;
            r_cnt  <= c_reload;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= sw;
            r_s2   <= r_s1;
            r_lsw  <= r_s2;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 != r_lsw) begin
                r_cnt <= c_reload;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_one;
            end else begin
                r_outp <= r_s2;
                r_rise <= r_s2 & ~r_outp;
                r_fall <= ~r_s2 & r_outp;
            end
        end
    end

    assign outp    = r_outp;
    assign invoutp = ~r_outp;
    assign rise    = r_rise;
    assign fall    = r_fall;

    generate
        if (HOLD > 0) begin : g_hold
            localparam int              c_hw   = cnt_width(HOLD);
            localparam logic [c_hw-1:0] c_hmax = c_hw'(HOLD);
            localparam logic [c_hw-1:0] c_hone = c_hw'(1);

            logic [c_hw-1:0] r_hcnt;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_hcnt <= '0;
                end else if (!r_outp) begin
                    r_hcnt <= '0;
                end else if (r_hcnt != c_hmax) begin
                    r_hcnt <= r_hcnt + c_hone;
                end
            end

            // Gated by the live level so hold drops in the same cycle as fall.
            assign hold = r_outp && (r_hcnt == c_hmax);
        end else begin : g_no_hold
            assign hold = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce
// Brief    : N independent debounced switch channels with edge and hold flags.
// Revision : 1.0
// ============================================================================
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int N      = c_default_n,
    parameter int BOUNCE = c_default_bounce,
    parameter int HOLD   = c_default_hold,
    parameter bit INIT   = c_default_init
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] sw,
    output logic [N-1:0] outp,
    output logic [N-1:0] invoutp,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] hold,
    output logic         any_change
);

    generate
        if ((N < c_n_min) || (N > c_n_max)) begin : g_bad_n
            $error("multi_debounce: N out of range 1..32");
        end
        if (BOUNCE < c_bounce_min) begin : g_bad_bounce
            $error("multi_debounce: BOUNCE must be at least 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            debounce_chan #(
                .BOUNCE (BOUNCE),
                .HOLD   (HOLD),
                .INIT   (INIT)
            ) u_chan (
                .CLK     (CLK),
                .RST     (RST),
                .sw      (sw[gi]),
                .outp    (outp[gi]),
                .invoutp (invoutp[gi]),
                .rise    (rise[gi]),
                .fall    (fall[gi]),
                .hold    (hold[gi])
            );
        end
    endgenerate

    assign any_change = |(rise | fall);

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_debounce
// Brief    : Directed scoreboard bench for multi_debounce (N=4, BOUNCE=4, HOLD=10).
// Revision : 1.0
// ============================================================================
module tb_multi_debounce;

    localparam int c_n = 4;

    logic           CLK;
    logic           RST;
    logic [c_n-1:0] sw;
    logic [c_n-1:0] outp;
    logic [c_n-1:0] invoutp;
    logic [c_n-1:0] rise;
    logic [c_n-1:0] fall;
    logic [c_n-1:0] hold;
    logic           any_change;

    multi_debounce #(
        .N      (c_n),
        .BOUNCE (4),
        .HOLD   (10),
        .INIT   (1'b0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sw         (sw),
        .outp       (outp),
        .invoutp    (invoutp),
        .rise       (rise),
        .fall       (fall),
        .hold       (hold),
        .any_change (any_change)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // From edge cyc on, outp/hold take these levels; rise/fall pulse only at cyc.
    typedef struct {
        int             cyc;
        logic [c_n-1:0] o;
        logic [c_n-1:0] r;
        logic [c_n-1:0] f;
        logic [c_n-1:0] h;
    } ev_t;

    ev_t            q[$];
    int             cyc      = 0;
    int             checks   = 0;
    int             failures = 0;
    logic [c_n-1:0] exp_outp = '0;
    logic [c_n-1:0] exp_hold = '0;
    logic [c_n-1:0] exp_rise;
    logic [c_n-1:0] exp_fall;

    task automatic chk(input string tag, input logic [c_n-1:0] obs, input logic [c_n-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input int at, input logic [c_n-1:0] o, input logic [c_n-1:0] r,
                        input logic [c_n-1:0] f, input logic [c_n-1:0] h);
        ev_t e;
        e.cyc = at; e.o = o; e.r = r; e.f = f; e.h = h;
        q.push_back(e);
    endtask

    // Advance n edges, comparing every output at each following negedge.
    task automatic tick(input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            exp_rise = '0;
            exp_fall = '0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                exp_outp = e.o;
                exp_hold = e.h;
                exp_rise = e.r;
                exp_fall = e.f;
            end
            chk("outp", outp, exp_outp);
            chk("invoutp", invoutp, ~exp_outp);
            chk("rise", rise, exp_rise);
            chk("fall", fall, exp_fall);
            chk("hold", hold, exp_hold);
            chk("any_change", {3'b000, any_change}, {3'b000, |(exp_rise | exp_fall)});
        end
    endtask

    initial begin
        int t0;
        RST = 1'b1;
        sw  = '0;
        tick(3);
        RST = 1'b0;
        tick(10);

        // Clean rising step on channel 0, then release it.
        t0 = cyc; sw[0] = 1'b1;
        push(t0 + 8,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
        push(t0 + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(20);
        t0 = cyc; sw[0] = 1'b0;
        push(t0 + 8,  4'b0000, 4'b0000, 4'b0001, 4'b0000);
        tick(12);

        // Bouncing input on channel 1: only the last toggle counts.
        sw[1] = 1'b1; tick(2);
        sw[1] = 1'b0; tick(2);
        t0 = cyc; sw[1] = 1'b1;
        push(t0 + 8,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        push(t0 + 18, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        tick(22);

        // Three-cycle glitch on channel 2 must never be accepted.
        sw[2] = 1'b1; tick(3);
        sw[2] = 1'b0; tick(15);

        // Hold behaviour on channel 3.
        t0 = cyc; sw[3] = 1'b1;
        push(t0 + 8,  4'b1010, 4'b1000, 4'b0000, 4'b0010);
        push(t0 + 18, 4'b1010, 4'b0000, 4'b0000, 4'b1010);
        tick(22);
        t0 = cyc; sw[3] = 1'b0;
        push(t0 + 8,  4'b0010, 4'b0000, 4'b1000, 4'b0010);
        tick(12);

        // Simultaneous rise on channel 0 and fall on channel 1.
        t0 = cyc; sw[0] = 1'b1; sw[1] = 1'b0;
        push(t0 + 8,  4'b0001, 4'b0001, 4'b0010, 4'b0000);
        push(t0 + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(20);
        t0 = cyc; sw[0] = 1'b0;
        push(t0 + 8,  4'b0000, 4'b0000, 4'b0001, 4'b0000);
        tick(12);

        // Reset on edge 5 of a pending acceptance restarts the full interval.
        t0 = cyc; sw[0] = 1'b1;
        tick(4);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        push(t0 + 13, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        push(t0 + 23, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(25);

        chk("scoreboard_drained", 4'(q.size()), 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
